// File: rtl/traffic_light_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl_param_pkg
// Brief    : Lamp codes, phase encodings and helpers for the traffic controller
// Revision : 1.0 - initial release
// ============================================================================
package traffic_light_ctrl_param_pkg;

    localparam logic [1:0] c_lamp_green  = 2'b00;
    localparam logic [1:0] c_lamp_red    = 2'b01;
    localparam logic [1:0] c_lamp_yellow = 2'b10;
    localparam logic [1:0] c_lamp_off    = 2'b11;

    localparam logic [1:0] c_ph_green   = 2'd0;
    localparam logic [1:0] c_ph_yellow  = 2'd1;
    localparam logic [1:0] c_ph_all_red = 2'd2;
    localparam logic [1:0] c_ph_flash   = 2'd3;

    // Direction index width; a single approach still needs one bit.
    function automatic int dir_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] lamp_code(input logic [1:0] phase,
                                             input logic       is_active,
                                             input logic       blink);
        logic [1:0] code;
        code = c_lamp_red;
        case (phase)
            c_ph_green:   code = is_active ? c_lamp_green  : c_lamp_red;
            c_ph_yellow:  code = is_active ? c_lamp_yellow : c_lamp_red;
            c_ph_all_red: code = c_lamp_red;
            default:      code = blink ? c_lamp_yellow : c_lamp_off;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl_param_rr_next.sv
`default_nettype none
// ============================================================================
// Module   : tlc_rr_next
// Brief    : Combinational round-robin picker: first requester after active_dir
// Revision : 1.0 - initial release
// ============================================================================
module tlc_rr_next
    import traffic_light_ctrl_param_pkg::*;
#(
    parameter int NUM_DIR = 2,
    parameter int DIR_W   = dir_w(NUM_DIR)
) (
    input  logic [DIR_W-1:0]   active_dir,
    input  logic [NUM_DIR-1:0] req,
    output logic [DIR_W-1:0]   next_dir
);

    always_comb begin
        int idx;
        idx = int'(active_dir) + 1;
        if (idx >= NUM_DIR) idx = idx - NUM_DIR;
        next_dir = DIR_W'(idx);
        // Walk from farthest to nearest so the nearest requester wins; k=NUM_DIR
        // wraps back onto the active direction itself.
        for (int k = NUM_DIR; k >= 1; k--) begin
            idx = int'(active_dir) + k;
            if (idx >= NUM_DIR) idx = idx - NUM_DIR;
            if (req[idx]) next_dir = DIR_W'(idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl_param
// Brief    : Timed round-robin traffic-light controller with hold and flash
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl_param
    import traffic_light_ctrl_param_pkg::*;
#(
    parameter int NUM_DIR     = 2,
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 10,
    parameter int YELLOW_CYC  = 3,
    parameter int ALL_RED_CYC = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_tick,
    input  logic [NUM_DIR-1:0]          i_sensor,
    input  logic                        i_hold,
    input  logic                        i_flash,
    output logic [2*NUM_DIR-1:0]        o_light,
    output logic [dir_w(NUM_DIR)-1:0]   o_active_dir,
    output logic [1:0]                  o_phase
);

    localparam int DIR_W = dir_w(NUM_DIR);
    localparam int CNT_W = $clog2(MAX_GREEN + 1);

    localparam logic [CNT_W-1:0] c_min_last = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_max_last = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yel_last = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] c_ar_last  = CNT_W'(ALL_RED_CYC - 1);

    logic [1:0]         r_phase;
    logic [DIR_W-1:0]   r_active_dir;
    logic [CNT_W-1:0]   r_timer;
    logic               r_blink;

    logic [NUM_DIR-1:0] w_own_mask;
    logic               w_other_req;
    logic               w_own_req;
    logic               w_leave_green;
    logic [DIR_W-1:0]   w_next_dir;

    assign w_own_mask    = NUM_DIR'(1) << r_active_dir;
    assign w_other_req   = |(i_sensor & ~w_own_mask);
    assign w_own_req     = |(i_sensor & w_own_mask);
    assign w_leave_green = !i_hold && w_other_req && (r_timer >= c_min_last) &&
                           (!w_own_req || (r_timer >= c_max_last));

    tlc_rr_next #(
        .NUM_DIR (NUM_DIR),
        .DIR_W   (DIR_W)
    ) u_rr_next (
        .active_dir (r_active_dir),
        .req        (i_sensor),
        .next_dir   (w_next_dir)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase      <= c_ph_green;
            r_active_dir <= '0;
            r_timer      <= '0;
            r_blink      <= 1'b0;
        end else if (i_flash) begin
            // Flash entry ignores the tick; once flashing, ticks drive the blink.
            if (r_phase != c_ph_flash) begin
                r_phase <= c_ph_flash;
                r_timer <= '0;
                r_blink <= 1'b0;
            end else if (i_tick) begin
                r_blink <= ~r_blink;
            end
        end else begin
            case (r_phase)
                c_ph_green: begin
                    if (i_tick) begin
                        if (w_leave_green) begin
                            r_phase <= c_ph_yellow;
                            r_timer <= '0;
                        end else if (r_timer < c_max_last) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                c_ph_yellow: begin
                    if (i_tick) begin
                        if (r_timer == c_yel_last) begin
                            r_phase <= c_ph_all_red;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                c_ph_all_red: begin
                    if (i_tick) begin
                        if (r_timer == c_ar_last) begin
                            r_phase      <= c_ph_green;
                            r_timer      <= '0;
                            r_active_dir <= w_next_dir;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                default: begin
                    r_phase <= c_ph_all_red;
                    r_timer <= '0;
                    r_blink <= 1'b0;
                end
            endcase
        end
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
        assign o_light[2*d +: 2] = lamp_code(r_phase, (r_active_dir == DIR_W'(d)), r_blink);
    end

    assign o_active_dir = r_active_dir;
    assign o_phase      = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_ctrl_param
// Brief    : Directed table-driven bench for the traffic-light controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] sensor = 2'b00;
    logic       hold = 1'b0;
    logic       flash = 1'b0;
    logic [3:0] light;
    logic [0:0] dir;
    logic [1:0] phase;

    logic       tick4 = 1'b0;
    logic [3:0] sensor4 = 4'b0000;
    logic       hold4 = 1'b0;
    logic       flash4 = 1'b0;
    logic [7:0] light4;
    logic [1:0] dir4;
    logic [1:0] phase4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl_param dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_sensor(sensor),
        .i_hold(hold), .i_flash(flash),
        .o_light(light), .o_active_dir(dir), .o_phase(phase)
    );

    traffic_light_ctrl_param #(.NUM_DIR(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_tick(tick4), .i_sensor(sensor4),
        .i_hold(hold4), .i_flash(flash4),
        .o_light(light4), .o_active_dir(dir4), .o_phase(phase4)
    );

    typedef struct packed {
        logic       tick;
        logic [1:0] sensor;
        logic       flash;
        logic [3:0] light;
        logic [1:0] phase;
        logic       dir;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Edges taken until the phase leaves p (bounded).
    task automatic run_len(input logic [1:0] p, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (phase == p && n < 40);
    endtask

    task automatic wait_phase(input string name, input logic [1:0] p, input int bound);
        int n;
        n = 0;
        while (phase != p && n < bound) begin
            step();
            n++;
        end
        chk(name, phase, p);
    endtask

    task automatic wait_phase4(input string name, input logic [1:0] p, input int bound);
        int n;
        n = 0;
        while (phase4 != p && n < bound) begin
            step();
            n++;
        end
        chk(name, phase4, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic ok;

        //              tick sens  fl light    ph  dir
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 4'b0100, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b0, 4'b0100, 2'd0, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 4'b0100, 2'd0, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 1'b0, 4'b0100, 2'd0, 1'b0};
        vecs[4]  = '{1'b1, 2'b10, 1'b0, 4'b0110, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 4'b0110, 2'd1, 1'b0};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 4'b0110, 2'd1, 1'b0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 4'b0110, 2'd1, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 4'b0101, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 4'b0101, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 4'b0001, 2'd0, 1'b1};
        vecs[14] = '{1'b1, 2'b01, 1'b0, 4'b1001, 2'd1, 1'b1};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 4'b1111, 2'd3, 1'b1};
        vecs[16] = '{1'b1, 2'b01, 1'b1, 4'b1010, 2'd3, 1'b1};
        vecs[17] = '{1'b0, 2'b01, 1'b1, 4'b1010, 2'd3, 1'b1};
        vecs[18] = '{1'b1, 2'b01, 1'b1, 4'b1111, 2'd3, 1'b1};
        vecs[19] = '{1'b0, 2'b01, 1'b0, 4'b0101, 2'd2, 1'b1};
        vecs[20] = '{1'b1, 2'b01, 1'b0, 4'b0101, 2'd2, 1'b1};
        vecs[21] = '{1'b1, 2'b01, 1'b0, 4'b0100, 2'd0, 1'b0};

        // Reset state
        do_reset();
        chk("reset_light", light, 4'b0100);
        chk("reset_phase", phase, 2'd0);
        chk("reset_dir", dir, 1'b0);
        chk("reset_light4", light4, 8'b01010100);

        // Basic sequencing, tick gating, flash entry/exit
        for (int i = 0; i < 22; i++) begin
            tick   = vecs[i].tick;
            sensor = vecs[i].sensor;
            flash  = vecs[i].flash;
            step();
            chk($sformatf("vec%0d_light", i), light, vecs[i].light);
            chk($sformatf("vec%0d_phase", i), phase, vecs[i].phase);
            chk($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
        end

        // Both roads busy: MAX_GREEN governs, alternation continues
        tick = 1'b0; flash = 1'b0; sensor = 2'b11;
        do_reset();
        tick = 1'b1;
        run_len(2'd0, n); chk("max_green_d0_len", n, 10);
        run_len(2'd1, n); chk("max_yellow_len", n, 3);
        run_len(2'd2, n); chk("max_allred_len", n, 2);
        chk("max_dir1", dir, 1'b1);
        run_len(2'd0, n); chk("max_green_d1_len", n, 10);
        run_len(2'd1, n);
        run_len(2'd2, n);
        chk("max_dir_back0", dir, 1'b0);

        // No requests: rest in green, then change as soon as another road asks
        tick = 1'b0; sensor = 2'b00;
        do_reset();
        tick = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (phase != 2'd0 || dir != 1'b0) ok = 1'b0;
        end
        chk("rest_green_50", ok, 1'b1);
        sensor = 2'b10;
        step();
        chk("rest_then_yellow_phase", phase, 2'd1);
        chk("rest_then_yellow_light", light, 4'b0110);

        // Hold overrides MAX_GREEN
        tick = 1'b0; sensor = 2'b11; hold = 1'b1;
        do_reset();
        tick = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (phase != 2'd0) ok = 1'b0;
        end
        chk("hold_keeps_green", ok, 1'b1);
        hold = 1'b0;
        step();
        chk("hold_release_yellow", phase, 2'd1);

        // Four approaches: wrap from dir1 past 2,3 to dir0
        tick = 1'b0; sensor = 2'b00;
        do_reset();
        sensor4 = 4'b0010;
        tick4 = 1'b1;
        wait_phase4("n4_reach_allred", 2'd2, 20);
        wait_phase4("n4_reach_green1", 2'd0, 20);
        chk("n4_dir1", dir4, 2'd1);
        sensor4 = 4'b0001;
        wait_phase4("n4_reach_allred2", 2'd2, 20);
        wait_phase4("n4_reach_green0", 2'd0, 20);
        chk("n4_dir_wrap0", dir4, 2'd0);
        chk("n4_light", light4, 8'b01010100);
        tick4 = 1'b0; sensor4 = 4'b0000;

        // Flash mid-yellow with tick every other cycle, exit, async reset mid-flash
        do_reset();
        sensor = 2'b10; tick = 1'b1;
        wait_phase("fl_reach_yellow", 2'd1, 20);
        step();
        flash = 1'b1; tick = 1'b0;
        step();
        chk("fl_entry_phase", phase, 2'd3);
        chk("fl_entry_off", light, 4'b1111);
        tick = 1'b1; step(); chk("fl_blink1", light, 4'b1010);
        tick = 1'b0; step(); chk("fl_hold1", light, 4'b1010);
        tick = 1'b1; step(); chk("fl_blink0", light, 4'b1111);
        tick = 1'b0; step(); chk("fl_dir_held", dir, 1'b0);
        flash = 1'b0; sensor = 2'b01;
        step();
        chk("fl_exit_allred", phase, 2'd2);
        chk("fl_exit_light", light, 4'b0101);
        tick = 1'b1; step(); chk("fl_allred_t1", phase, 2'd2);
        tick = 1'b0; step(); chk("fl_allred_gap", phase, 2'd2);
        tick = 1'b1; step();
        chk("fl_green_phase", phase, 2'd0);
        chk("fl_green_same_dir", dir, 1'b0);
        flash = 1'b1; tick = 1'b0; step();
        tick = 1'b1; step();
        chk("fl_again_blink", light, 4'b1010);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_phase", phase, 2'd0);
        chk("async_rst_light", light, 4'b0100);
        chk("async_rst_dir", dir, 1'b0);
        flash = 1'b0; tick = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_phase", phase, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
